calc_result_bcd: RTL and testbench

CALC_RESULT_BCD -- requirements
Module: calc_result_bcd

---
 rtl/calc_result_bcd.sv | 133 +++++++++++++
 tb/tb_calc_result_bcd.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/calc_result_bcd.sv
// calc_result_bcd
//   Captures the result of a 6-bit add/sub stage and converts its magnitude
//   to BCD. The conversion uses a double-dabble shifter that runs for 7 cycles.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   request capture of the current adder result (ignored while busy)
//   sum[5:0]  in   sum bus of the add/sub stage
//   cout[5:0] in   per-bit carries; cout[5] = final carry-out, cout[4] = carry into bit 5
//   sub_mode  in   1 = two's-complement subtraction result, 0 = unsigned addition
//   busy      out  conversion in progress
//   done      out  one-cycle pulse when neg/ovf/hund/tens/ones are updated
//   neg       out  result is negative
//   ovf       out  signed overflow
//   hund      out  BCD hundreds digit (0 or 1)
//   tens[3:0] out  BCD tens digit
//   ones[3:0] out  BCD ones digit
module calc_result_bcd (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] sum,
  input  logic [5:0] cout,
  input  logic       sub_mode,
  output logic       busy,
  output logic       done,
  output logic       neg,
  output logic       ovf,
  output logic       hund,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_reg;
  logic [2:0]  cnt_reg;
  logic [6:0]  mag_reg;
  logic        hund_s_reg;
  logic [7:0]  bcd_s_reg;     // {tens, ones} scratch digits
  logic        neg_l_reg;
  logic        ovf_l_reg;

  // Only the two top carries matter; the lower carries are part of the bus
  // but carry no information this block needs.
  logic unused_cout;
  assign unused_cout = ^cout[3:0];

  // Magnitude selected at capture time.
  logic [6:0] sext_sum;
  logic [6:0] mag_in;
  always_comb begin
    sext_sum = {sum[5], sum};
    if (!sub_mode)
      mag_in = {cout[5], sum};
    else if (sum[5])
      mag_in = ~sext_sum + 7'd1;   // 7-bit negation so -32 maps to 32
    else
      mag_in = sext_sum;
  end

  // Double-dabble step: add 3 to each scratch digit >= 5, then shift left.
  // The hundreds digit never exceeds 1, so it needs no adjustment.
  logic [7:0] bcd_adj;
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_s_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_s_reg[gi*4 +: 4] + 4'd3 :
                                  bcd_s_reg[gi*4 +: 4];
    end
  endgenerate

  logic       hund_next;
  logic [7:0] bcd_next;
  assign hund_next = bcd_adj[7];
  assign bcd_next  = {bcd_adj[6:0], mag_reg[6]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= 3'd0;
      mag_reg    <= 7'd0;
      hund_s_reg <= 1'b0;
      bcd_s_reg  <= 8'd0;
      neg_l_reg  <= 1'b0;
      ovf_l_reg  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      neg        <= 1'b0;
      ovf        <= 1'b0;
      hund       <= 1'b0;
      tens       <= 4'd0;
      ones       <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg  <= SHIFT;
            busy       <= 1'b1;
            cnt_reg    <= 3'd0;
            hund_s_reg <= 1'b0;
            bcd_s_reg  <= 8'd0;
            mag_reg    <= mag_in;
            neg_l_reg  <= sub_mode & sum[5];
            ovf_l_reg  <= sub_mode & (cout[5] ^ cout[4]);
          end
        end
        SHIFT: begin
          hund_s_reg <= hund_next;
          bcd_s_reg  <= bcd_next;
          mag_reg    <= {mag_reg[5:0], 1'b0};
          cnt_reg    <= cnt_reg + 3'd1;
          // Seventh shift: publish the just-completed digits directly.
          if (cnt_reg == 3'd6) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            hund      <= hund_next;
            tens      <= bcd_next[7:4];
            ones      <= bcd_next[3:0];
            neg       <= neg_l_reg;
            ovf       <= ovf_l_reg;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_result_bcd.sv
// Directed testbench for calc_result_bcd with hand-computed expected results.
module tb_calc_result_bcd;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] sum;
  logic [5:0] cout;
  logic       sub_mode;
  logic       busy, done, neg, ovf, hund;
  logic [3:0] tens, ones;

  int checks;
  int errors;

  calc_result_bcd dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sum      (sum),
    .cout     (cout),
    .sub_mode (sub_mode),
    .busy     (busy),
    .done     (done),
    .neg      (neg),
    .ovf      (ovf),
    .hund     (hund),
    .tens     (tens),
    .ones     (ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end else begin
      $display("ok   %s value=%0h", tag, obs);
    end
  endtask

  // Packed result view: {hund, tens, ones, neg, ovf}
  function automatic logic [10:0] res(input logic h, input logic [3:0] t,
                                      input logic [3:0] o, input logic n, input logic v);
    return {h, t, o, n, v};
  endfunction

  // One conversion; scrambles the inputs after capture and measures latency.
  task automatic run(input string tag, input logic [5:0] s, input logic c5,
                     input logic c4, input logic sm, input logic [10:0] exp);
    int lat;
    @(negedge clk);
    sum = s; cout = {c5, c4, 4'b0000}; sub_mode = sm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sum = ~s; cout = ~cout; sub_mode = ~sm;
    check({tag, "_busy"}, busy, 1'b1);
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    check({tag, "_lat"}, lat, 7);
    check({tag, "_res"}, res(hund, tens, ones, neg, ovf), exp);
    @(posedge clk); #1;
    check({tag, "_idle"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int nd, first, d1, d2;
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; sum = 6'd0; cout = 6'd0; sub_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {busy, done, res(hund, tens, ones, neg, ovf)}, 13'd0);
    @(negedge clk); rst_n = 1'b1;

    run("add_25_20",   6'b101101, 1'b0, 1'b0, 1'b0, res(1'b0, 4'd4, 4'd5, 1'b0, 1'b0));
    run("add_63_63",   6'b111110, 1'b1, 1'b0, 1'b0, res(1'b1, 4'd2, 4'd6, 1'b0, 1'b0));
    run("sub_5_12",    6'b111001, 1'b0, 1'b0, 1'b1, res(1'b0, 4'd0, 4'd7, 1'b1, 1'b0));
    run("sub_m32",     6'b100000, 1'b0, 1'b0, 1'b1, res(1'b0, 4'd3, 4'd2, 1'b1, 1'b0));
    run("sub_ovf",     6'b011111, 1'b1, 1'b0, 1'b1, res(1'b0, 4'd3, 4'd1, 1'b0, 1'b1));
    run("sub_pos_10",  6'b001010, 1'b1, 1'b1, 1'b1, res(1'b0, 4'd1, 4'd0, 1'b0, 1'b0));

    // start re-pulsed with a new sum during busy: one done, original result.
    @(negedge clk);
    sum = 6'b101101; cout = 6'd0; sub_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0; first = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin nd++; if (first == 0) first = i; end
      if (i == 3) begin start = 1'b1; sum = 6'b000011; end
      if (i == 4) start = 1'b0;
    end
    check("repulse_ndone", nd, 1);
    check("repulse_lat", first, 7);
    check("repulse_res", res(hund, tens, ones, neg, ovf), res(1'b0, 4'd4, 4'd5, 1'b0, 1'b0));

    // start held high across done: back-to-back conversions 8 cycles apart.
    @(negedge clk);
    sum = 6'b001100; cout = 6'd0; sub_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    sum = 6'b111111;
    d1 = 0; d2 = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        if (d1 == 0) begin
          d1 = i;
          check("held_res1", res(hund, tens, ones, neg, ovf), res(1'b0, 4'd1, 4'd2, 1'b0, 1'b0));
        end else if (d2 == 0) begin
          d2 = i;
          check("held_res2", res(hund, tens, ones, neg, ovf), res(1'b0, 4'd6, 4'd3, 1'b0, 1'b0));
          start = 1'b0;
        end
      end
      if (d1 != 0 && i == d1 + 1) check("held_busy", busy, 1'b1);
    end
    start = 1'b0;
    check("held_d1", d1, 7);
    check("held_d2", d2, 15);
    repeat (10) @(posedge clk);

    // Reset asserted at SHIFT cycle 3: everything clears, no done.
    @(negedge clk);
    sum = 6'b111110; cout = 6'b100000; sub_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_outs", {busy, done, res(hund, tens, ones, neg, ovf)}, 13'd0);
    @(negedge clk); rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("rst_mid_nodone", nd, 0);
    check("rst_mid_hold", res(hund, tens, ones, neg, ovf), 11'd0);

    run("post_rst", 6'b111001, 1'b0, 1'b0, 1'b1, res(1'b0, 4'd0, 4'd7, 1'b1, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
